inst_fetch_queue: RTL

- Fetch front-end that sits directly upstream of the core's Ifetch stage, replacing the zero-latency ROM path.
- Owns the fetch PC and issues in-order instruction read requests to the memory bus over a valid/ready handshake.
- Buffers returned instructions with their addresses in a small circular queue and presents them to the core with valid/ready.
- Handles redirects from the controller (branch/jump) by flushing the queue and discarding responses that were in flight at the time of the redirect.

---
 rtl/inst_fetch_queue_if.sv | 34 +++
 rtl/inst_fetch_queue.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_queue_if
// Function : Controller, core-side and memory-bus signals of the fetch queue.
// Revision : 1.0
// ============================================================================
interface inst_fetch_queue_if #(
  parameter int WIDTH      = 64,
  parameter int INST_WIDTH = 32
) ();
  logic                  jump_en;
  logic [WIDTH-1:0]      jump_addr;
  logic                  inst_ready;
  logic                  inst_valid;
  logic [INST_WIDTH-1:0] inst_o;
  logic [WIDTH-1:0]      inst_addr_o;
  logic                  req_valid;
  logic [WIDTH-1:0]      req_addr;
  logic                  req_ready;
  logic                  rsp_valid;
  logic [INST_WIDTH-1:0] rsp_data;
  logic                  flush_pending;

  modport master (
    input  jump_en, jump_addr, inst_ready, req_ready, rsp_valid, rsp_data,
    output inst_valid, inst_o, inst_addr_o, req_valid, req_addr, flush_pending
  );

  modport slave (
    output jump_en, jump_addr, inst_ready, req_ready, rsp_valid, rsp_data,
    input  inst_valid, inst_o, inst_addr_o, req_valid, req_addr, flush_pending
  );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_queue
// Function : Fetch PC owner, in-order memory requester and instruction queue.
// Revision : 1.0
// ============================================================================
module inst_fetch_queue #(
  parameter int               WIDTH      = 64,
  parameter int               INST_WIDTH = 32,
  parameter int               DEPTH      = 4,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(64'h8000_0000)
) (
  input  logic               clk,
  input  logic               rst,
  inst_fetch_queue_if.master bus
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam int c_SUM_W = c_CNT_W + 1;

  logic [WIDTH-1:0]      fetch_pc_q, fetch_pc_d;
  logic                  req_valid_q, req_valid_d;
  logic [WIDTH-1:0]      req_addr_q, req_addr_d;
  logic [WIDTH-1:0]      slot_addr_q [DEPTH];
  logic [WIDTH-1:0]      slot_addr_d [DEPTH];
  logic [INST_WIDTH-1:0] slot_data_q [DEPTH];
  logic [INST_WIDTH-1:0] slot_data_d [DEPTH];
  logic [DEPTH-1:0]      slot_filled_q, slot_filled_d;
  logic [c_PTR_W-1:0]    alloc_ptr_q, alloc_ptr_d;
  logic [c_PTR_W-1:0]    fill_ptr_q, fill_ptr_d;
  logic [c_PTR_W-1:0]    head_ptr_q, head_ptr_d;
  logic [c_CNT_W-1:0]    used_q, used_d;
  logic [c_CNT_W-1:0]    unfilled_q, unfilled_d;
  logic [c_CNT_W-1:0]    drop_cnt_q, drop_cnt_d;

  logic                  w_inst_valid;
  logic                  w_pop;
  logic                  w_room;
  logic                  w_launch;
  logic                  w_fill;
  logic                  w_drop;
  logic [WIDTH-1:0]      w_jump_tgt;

  assign w_inst_valid = (used_q != '0) && slot_filled_q[head_ptr_q];
  assign w_pop        = w_inst_valid && bus.inst_ready && !bus.jump_en;
  // Slots being popped this cycle are already free for a new launch.
  assign w_room       = ({1'b0, used_q} - c_SUM_W'(w_pop) + {1'b0, drop_cnt_q})
                        < c_SUM_W'(DEPTH);
  assign w_launch     = (!req_valid_q || bus.req_ready) && w_room && !bus.jump_en;
  assign w_fill       = bus.rsp_valid && (drop_cnt_q == '0);
  assign w_drop       = bus.rsp_valid && (drop_cnt_q != '0);
  assign w_jump_tgt   = bus.jump_addr & ~WIDTH'(3);

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    req_valid_d   = req_valid_q;
    req_addr_d    = req_addr_q;
    slot_addr_d   = slot_addr_q;
    slot_data_d   = slot_data_q;
    slot_filled_d = slot_filled_q;
    alloc_ptr_d   = alloc_ptr_q;
    fill_ptr_d    = fill_ptr_q;
    head_ptr_d    = head_ptr_q;
    used_d        = used_q;
    unfilled_d    = unfilled_q;
    drop_cnt_d    = drop_cnt_q;

    if (w_launch) begin
      req_valid_d = 1'b1;
      req_addr_d  = fetch_pc_q;
      fetch_pc_d  = fetch_pc_q + WIDTH'(4);
    end else if (req_valid_q && bus.req_ready) begin
      req_valid_d = 1'b0;
    end

    if (bus.jump_en) begin
      // Every unfilled slot still owes a response; a response arriving now settles one.
      fetch_pc_d    = w_jump_tgt;
      slot_filled_d = '0;
      alloc_ptr_d   = '0;
      fill_ptr_d    = '0;
      head_ptr_d    = '0;
      used_d        = '0;
      unfilled_d    = '0;
      drop_cnt_d    = drop_cnt_q + unfilled_q - c_CNT_W'(bus.rsp_valid);
    end else begin
      if (w_pop) begin
        slot_filled_d[head_ptr_q] = 1'b0;
        head_ptr_d                = head_ptr_q + c_PTR_W'(1);
      end
      if (w_launch) begin
        slot_addr_d[alloc_ptr_q]   = fetch_pc_q;
        slot_filled_d[alloc_ptr_q] = 1'b0;
        alloc_ptr_d                = alloc_ptr_q + c_PTR_W'(1);
      end
      if (w_fill) begin
        slot_data_d[fill_ptr_q]   = bus.rsp_data;
        slot_filled_d[fill_ptr_q] = 1'b1;
        fill_ptr_d                = fill_ptr_q + c_PTR_W'(1);
      end
      if (w_drop) begin
        drop_cnt_d = drop_cnt_q - c_CNT_W'(1);
      end
      used_d     = used_q + c_CNT_W'(w_launch) - c_CNT_W'(w_pop);
      unfilled_d = unfilled_q + c_CNT_W'(w_launch) - c_CNT_W'(w_fill);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      req_valid_q   <= 1'b0;
      req_addr_q    <= RESET_PC;
      for (int i = 0; i < DEPTH; i++) begin
        slot_addr_q[i] <= '0;
        slot_data_q[i] <= '0;
      end
      slot_filled_q <= '0;
      alloc_ptr_q   <= '0;
      fill_ptr_q    <= '0;
      head_ptr_q    <= '0;
      used_q        <= '0;
      unfilled_q    <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      req_valid_q   <= req_valid_d;
      req_addr_q    <= req_addr_d;
      slot_addr_q   <= slot_addr_d;
      slot_data_q   <= slot_data_d;
      slot_filled_q <= slot_filled_d;
      alloc_ptr_q   <= alloc_ptr_d;
      fill_ptr_q    <= fill_ptr_d;
      head_ptr_q    <= head_ptr_d;
      used_q        <= used_d;
      unfilled_q    <= unfilled_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign bus.inst_valid    = w_inst_valid;
  assign bus.inst_o        = slot_data_q[head_ptr_q];
  assign bus.inst_addr_o   = slot_addr_q[head_ptr_q];
  assign bus.req_valid     = req_valid_q;
  assign bus.req_addr      = req_addr_q;
  assign bus.flush_pending = (drop_cnt_q != '0);

endmodule
`default_nettype wire
